motion_bbox_detector: RTL and testbench
=======================================

// Module: motion_bbox_detector
// PURPOSE
//  Consumes the eroded binary motion mask (vsync/href/clken + 1-bit pixel) from the
//  erosion stage and measures the bounding box and pixel count of all foreground pixels
//  in each frame. Passes the binary stream through, registered, for display overlay.
//  Publishes box coordinates once per frame, at frame end, for target-tracking logic.
// PARAMETERS
//  IMG_HDISP   10'd640  active pixels per line; x range 0..IMG_HDISP-1
//  IMG_VDISP   10'd480  active lines per frame; y range 0..IMG_VDISP-1
//  MIN_PIXELS  19'd16   minimum foreground count for box_valid=1
// PORTS
//  sys_clk           in   1   system clock
//  sys_rst_n         in   1   synchronous reset, active low
//  per_frame_vsync   in   1   frame valid; high for the whole frame
//  per_frame_href    in   1   line valid
//  per_frame_clken   in   1   pixel strobe
//  per_img_Bit       in   1   eroded mask pixel (1 = foreground)
//  post_frame_vsync  out  1   per_frame_vsync delayed 1 clk
//  post_frame_href   out  1   per_frame_href delayed 1 clk
//  post_frame_clken  out  1   per_frame_clken delayed 1 clk
//  post_img_Bit      out  1   per_img_Bit delayed 1 clk
//  box_x_min/x_max   out  10  horizontal bounds of last completed frame
//  box_y_min/y_max   out  10  vertical bounds of last completed frame
//  box_pix_cnt       out  19  foreground pixel count of last completed frame
//  box_valid         out  1   1 = box_pix_cnt >= MIN_PIXELS
//  box_update        out  1   1-clk pulse when box_* outputs change
// BEHAVIOUR
//  - Reset (sys_rst_n=0 at clk edge): all outputs 0, state IDLE, counters 0.
//  - Pixel accepted only when vsync & href & clken all 1 in the same cycle.
//  - x_cnt: +1 per accepted pixel; cleared on href falling edge; saturates at IMG_HDISP-1.
//  - y_cnt: +1 on href falling edge while ACTIVE; cleared at frame start; saturates
//    at IMG_VDISP-1. Pixels beyond saturation are still counted, coordinate clamped.
//  - Edges detected against 1-clk registered copies of vsync/href.
//  - FSM: IDLE -> ACTIVE on vsync rising edge (clear x/y/cnt, x_min=IMG_HDISP-1,
//    y_min=IMG_VDISP-1, x_max=y_max=0). ACTIVE: on accepted pixel with Bit=1,
//    cnt+1, update min/max with current (x_cnt,y_cnt). ACTIVE -> LATCH on vsync
//    falling edge. LATCH -> IDLE after exactly 1 clk, registering box_* outputs.
//  - box_update high exactly 1 clk, 2 clks after first cycle vsync samples low;
//    box_* valid in that cycle and held until next update.
//  - cnt < MIN_PIXELS: box_valid=0, all four coordinates forced 0; box_pix_cnt real.
//  - cnt saturates at 2^19-1 (never wraps).
//  - Vsync rising edge seen in IDLE only; vsync falling in IDLE ignored (no update).
//  - Reset mid-frame: partial frame discarded, no box_update; FSM waits for next
//    vsync rising edge (a frame already in progress at reset release is skipped).
//  - Pass-through path independent of FSM; latency fixed at 1 clk.
// TESTING
//  1. 640x480 all-zero frame -> box_update once, box_pix_cnt=0, box_valid=0, coords 0.
//  2. 4x4 block at x=100..103,y=50..53 -> x 100/103, y 50/53, cnt=16, box_valid=1.
//  3. Two pixels (0,0),(639,479) plus 14 at (320,240) row -> x 0/639, y 0/479, cnt=16.
//  4. 15 foreground pixels -> box_valid=0, coords 0, box_pix_cnt=15.
//  5. Reset asserted at line 200 of a frame -> no box_update for it; next full frame
//     reports correctly; clken gaps inside href do not shift x coordinates.
//  6. Random mask stream -> post_* equal per_* delayed exactly 1 clk, every cycle.

Source files
------------

// File: rtl/motion_bbox_detector.sv
`default_nettype none
// ============================================================================
// Module      : motion_bbox_detector
// Description : Measures the bounding box and foreground pixel count of a
//               binary motion mask over each frame, publishing the result once
//               per frame at frame end. The mask stream is passed through with
//               a fixed one-clock delay for display overlay.
// Revision    : 1.0 - initial release
// ============================================================================
module motion_bbox_detector #(
    parameter logic [9:0]  IMG_HDISP  = 10'd640,
    parameter logic [9:0]  IMG_VDISP  = 10'd480,
    parameter logic [18:0] MIN_PIXELS = 19'd16
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    input  logic        per_img_Bit,
    output logic        post_frame_vsync,
    output logic        post_frame_href,
    output logic        post_frame_clken,
    output logic        post_img_Bit,
    output logic [9:0]  box_x_min,
    output logic [9:0]  box_x_max,
    output logic [9:0]  box_y_min,
    output logic [9:0]  box_y_max,
    output logic [18:0] box_pix_cnt,
    output logic        box_valid,
    output logic        box_update
);

    localparam logic [1:0]  c_st_idle   = 2'd0;
    localparam logic [1:0]  c_st_active = 2'd1;
    localparam logic [1:0]  c_st_latch  = 2'd2;
    localparam logic [9:0]  c_x_last    = IMG_HDISP - 10'd1;
    localparam logic [9:0]  c_y_last    = IMG_VDISP - 10'd1;
    localparam logic [18:0] c_cnt_max   = 19'h7FFFF;

    logic [1:0]  r_state;
    logic        r_vsync_d;
    logic        r_href_d;
    logic        r_seen_low;
    logic [9:0]  r_x_cnt;
    logic [9:0]  r_y_cnt;
    logic [18:0] r_pix_cnt;
    logic [9:0]  r_x_min;
    logic [9:0]  r_x_max;
    logic [9:0]  r_y_min;
    logic [9:0]  r_y_max;

    logic w_vs_rise;
    logic w_vs_fall;
    logic w_href_fall;
    logic w_accept;

    // A rising edge only counts once vsync has been seen low since reset, so a
    // frame already in progress when reset is released is skipped entirely.
    assign w_vs_rise   = per_frame_vsync & ~r_vsync_d & r_seen_low;
    assign w_vs_fall   = ~per_frame_vsync & r_vsync_d;
    assign w_href_fall = ~per_frame_href & r_href_d;
    assign w_accept    = per_frame_vsync & per_frame_href & per_frame_clken;

    // Fixed one-clock pass-through of the mask stream, independent of the FSM.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            post_frame_vsync <= 1'b0;
            post_frame_href  <= 1'b0;
            post_frame_clken <= 1'b0;
            post_img_Bit     <= 1'b0;
        end else begin
            post_frame_vsync <= per_frame_vsync;
            post_frame_href  <= per_frame_href;
            post_frame_clken <= per_frame_clken;
            post_img_Bit     <= per_img_Bit;
        end
    end

    // Registered sync copies used for edge detection, plus the "seen low" arm flag.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_vsync_d  <= 1'b0;
            r_href_d   <= 1'b0;
            r_seen_low <= 1'b0;
        end else begin
            r_vsync_d <= per_frame_vsync;
            r_href_d  <= per_frame_href;
            if (!per_frame_vsync) begin
                r_seen_low <= 1'b1;
            end
        end
    end

    // Frame FSM: accumulate during ACTIVE, publish the box on the LATCH cycle.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state     <= c_st_idle;
            r_x_cnt     <= 10'd0;
            r_y_cnt     <= 10'd0;
            r_pix_cnt   <= 19'd0;
            r_x_min     <= 10'd0;
            r_x_max     <= 10'd0;
            r_y_min     <= 10'd0;
            r_y_max     <= 10'd0;
            box_x_min   <= 10'd0;
            box_x_max   <= 10'd0;
            box_y_min   <= 10'd0;
            box_y_max   <= 10'd0;
            box_pix_cnt <= 19'd0;
            box_valid   <= 1'b0;
            box_update  <= 1'b0;
        end else begin
            box_update <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_vs_rise) begin
                        r_state   <= c_st_active;
                        r_x_cnt   <= 10'd0;
                        r_y_cnt   <= 10'd0;
                        r_pix_cnt <= 19'd0;
                        r_x_min   <= c_x_last;
                        r_y_min   <= c_y_last;
                        r_x_max   <= 10'd0;
                        r_y_max   <= 10'd0;
                    end
                end
                c_st_active: begin
                    if (w_vs_fall) begin
                        r_state <= c_st_latch;
                    end
                    if (w_accept) begin
                        // Coordinates clamp at the last column; pixels beyond still count.
                        if (r_x_cnt != c_x_last) begin
                            r_x_cnt <= r_x_cnt + 10'd1;
                        end
                        if (per_img_Bit) begin
                            if (r_pix_cnt != c_cnt_max) begin
                                r_pix_cnt <= r_pix_cnt + 19'd1;
                            end
                            if (r_x_cnt < r_x_min) r_x_min <= r_x_cnt;
                            if (r_x_cnt > r_x_max) r_x_max <= r_x_cnt;
                            if (r_y_cnt < r_y_min) r_y_min <= r_y_cnt;
                            if (r_y_cnt > r_y_max) r_y_max <= r_y_cnt;
                        end
                    end else if (w_href_fall) begin
                        r_x_cnt <= 10'd0;
                        if (r_y_cnt != c_y_last) begin
                            r_y_cnt <= r_y_cnt + 10'd1;
                        end
                    end
                end
                c_st_latch: begin
                    r_state     <= c_st_idle;
                    box_update  <= 1'b1;
                    box_pix_cnt <= r_pix_cnt;
                    // Too few pixels: report the count but suppress the box.
                    if (r_pix_cnt >= MIN_PIXELS) begin
                        box_valid <= 1'b1;
                        box_x_min <= r_x_min;
                        box_x_max <= r_x_max;
                        box_y_min <= r_y_min;
                        box_y_max <= r_y_max;
                    end else begin
                        box_valid <= 1'b0;
                        box_x_min <= 10'd0;
                        box_x_max <= 10'd0;
                        box_y_min <= 10'd0;
                        box_y_max <= 10'd0;
                    end
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_motion_bbox_detector.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_motion_bbox_detector
// Description : Self-checking bench for motion_bbox_detector. Frames are
//               described in a vector table; expected boxes are queued when a
//               frame is driven and compared when box_update fires.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_motion_bbox_detector;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        per_frame_vsync;
    logic        per_frame_href;
    logic        per_frame_clken;
    logic        per_img_Bit;
    logic        post_frame_vsync;
    logic        post_frame_href;
    logic        post_frame_clken;
    logic        post_img_Bit;
    logic [9:0]  box_x_min;
    logic [9:0]  box_x_max;
    logic [9:0]  box_y_min;
    logic [9:0]  box_y_max;
    logic [18:0] box_pix_cnt;
    logic        box_valid;
    logic        box_update;

    motion_bbox_detector dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .per_frame_vsync  (per_frame_vsync),
        .per_frame_href   (per_frame_href),
        .per_frame_clken  (per_frame_clken),
        .per_img_Bit      (per_img_Bit),
        .post_frame_vsync (post_frame_vsync),
        .post_frame_href  (post_frame_href),
        .post_frame_clken (post_frame_clken),
        .post_img_Bit     (post_img_Bit),
        .box_x_min        (box_x_min),
        .box_x_max        (box_x_max),
        .box_y_min        (box_y_min),
        .box_y_max        (box_y_max),
        .box_pix_cnt      (box_pix_cnt),
        .box_valid        (box_valid),
        .box_update       (box_update)
    );

    always #5 sys_clk = ~sys_clk;

    // Frame description plus the box the frame must produce.
    typedef struct {
        string name;
        int    nlines;
        int    rect_en, rx0, rx1, ry0, ry1;
        int    npts, p0x, p0y, p1x, p1y;
        int    gaps;
        int    xmin, xmax, ymin, ymax, cnt, valid;
    } vec_t;

    typedef struct {
        string name;
        int    xmin, xmax, ymin, ymax, cnt, valid;
    } exp_t;

    vec_t vecs[7];
    exp_t exp_q[$];

    int   checks    = 0;
    int   errors    = 0;
    int   n_upd     = 0;
    int   edge_n    = 0;
    int   fall_edge = -10;
    logic vs_prev   = 1'b0;

    task automatic chk(input string nm, input int act, input int want);
        checks++;
        if (act != want) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, want);
        end
    endtask

    function automatic int fg(input int i, input int x, input int y);
        int r;
        r = 0;
        if (vecs[i].rect_en != 0 && x >= vecs[i].rx0 && x <= vecs[i].rx1 &&
            y >= vecs[i].ry0 && y <= vecs[i].ry1) r = 1;
        if (vecs[i].npts > 0 && x == vecs[i].p0x && y == vecs[i].p0y) r = 1;
        if (vecs[i].npts > 1 && x == vecs[i].p1x && y == vecs[i].p1y) r = 1;
        return r;
    endfunction

    // Lines are only as long as the rightmost foreground pixel needs.
    function automatic int line_len(input int i, input int y);
        int len;
        len = 2;
        if (vecs[i].rect_en != 0 && y >= vecs[i].ry0 && y <= vecs[i].ry1 && vecs[i].rx1 + 1 > len)
            len = vecs[i].rx1 + 1;
        if (vecs[i].npts > 0 && y == vecs[i].p0y && vecs[i].p0x + 1 > len) len = vecs[i].p0x + 1;
        if (vecs[i].npts > 1 && y == vecs[i].p1y && vecs[i].p1x + 1 > len) len = vecs[i].p1x + 1;
        return len;
    endfunction

    // Drive one frame; abort_line >= 0 pulses reset at the start of that line.
    task automatic drive_frame(input int i, input int abort_line);
        int   len;
        int   x;
        exp_t e;
        if (abort_line < 0) begin
            e.name  = vecs[i].name;
            e.xmin  = vecs[i].xmin;
            e.xmax  = vecs[i].xmax;
            e.ymin  = vecs[i].ymin;
            e.ymax  = vecs[i].ymax;
            e.cnt   = vecs[i].cnt;
            e.valid = vecs[i].valid;
            exp_q.push_back(e);
        end
        per_frame_vsync = 1'b1;
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        per_img_Bit     = 1'b0;
        repeat (2) @(negedge sys_clk);
        for (int y = 0; y < vecs[i].nlines; y++) begin
            if (y == abort_line) begin
                sys_rst_n = 1'b0;
                repeat (2) @(negedge sys_clk);
                sys_rst_n = 1'b1;
            end
            len = line_len(i, y);
            x   = 0;
            per_frame_href = 1'b1;
            while (x < len) begin
                if (vecs[i].gaps != 0 && $urandom_range(0, 3) == 0) begin
                    per_frame_clken = 1'b0;
                    per_img_Bit     = 1'($urandom_range(0, 1));
                end else begin
                    per_frame_clken = 1'b1;
                    per_img_Bit     = 1'(fg(i, x, y));
                    x++;
                end
                @(negedge sys_clk);
            end
            per_frame_href  = 1'b0;
            per_frame_clken = 1'b0;
            per_img_Bit     = 1'b0;
            @(negedge sys_clk);
        end
        per_frame_vsync = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    task automatic wait_update(input string nm);
        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge sys_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL update_timeout_%s got pending %0d want 0", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Monitor: pass-through every edge, and scoreboard pop on box_update.
    always @(posedge sys_clk) begin
        logic [3:0] smp;
        logic       rst_smp;
        exp_t       e;
        smp     = {per_frame_vsync, per_frame_href, per_frame_clken, per_img_Bit};
        rst_smp = sys_rst_n;
        edge_n++;
        if (vs_prev && !per_frame_vsync) fall_edge = edge_n;
        vs_prev = per_frame_vsync;
        #1;
        checks++;
        if ({post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit} !== (rst_smp ? smp : 4'b0)) begin
            errors++;
            $display("FAIL passthru edge %0d got %b want %b", edge_n,
                     {post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit},
                     (rst_smp ? smp : 4'b0));
        end
        if (box_update === 1'b1) begin
            n_upd++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_update edge %0d got 1 want 0", edge_n);
            end else begin
                e = exp_q.pop_front();
                chk({e.name, "_x_min"}, int'(box_x_min), e.xmin);
                chk({e.name, "_x_max"}, int'(box_x_max), e.xmax);
                chk({e.name, "_y_min"}, int'(box_y_min), e.ymin);
                chk({e.name, "_y_max"}, int'(box_y_max), e.ymax);
                chk({e.name, "_cnt"},   int'(box_pix_cnt), e.cnt);
                chk({e.name, "_valid"}, int'(box_valid), e.valid);
                chk({e.name, "_latency"}, edge_n - fall_edge, 1);
            end
        end
    end

    initial begin
        int upd_before;

        //          name     lines rect x0  x1  y0  y1   pts p0x p0y p1x  p1y  gaps  xmin xmax ymin ymax cnt valid
        vecs[0] = '{"zero",    480, 0,   0,  0,  0,  0,   0,  0,  0,  0,   0,   0,    0,   0,   0,   0,  0,  0};
        vecs[1] = '{"block",    60, 1, 100,103, 50, 53,   0,  0,  0,  0,   0,   0,  100, 103,  50,  53, 16,  1};
        vecs[2] = '{"corners", 480, 1, 320,333,240,240,   2,  0,  0,639, 479,   0,    0, 639,   0, 479, 16,  1};
        vecs[3] = '{"fifteen",  10, 1,  10, 24,  5,  5,   0,  0,  0,  0,   0,   0,    0,   0,   0,   0, 15,  0};
        vecs[4] = '{"gaps",     12, 1,   7,  9,  3,  8,   0,  0,  0,  0,   0,   1,    7,   9,   3,   8, 18,  1};
        vecs[5] = '{"xsat",      4, 1, 650,665,  2,  2,   0,  0,  0,  0,   0,   0,  639, 639,   2,   2, 16,  1};
        vecs[6] = '{"ysat",    484, 1,   0, 15,482,482,   0,  0,  0,  0,   0,   0,    0,  15, 479, 479, 16,  1};

        sys_rst_n       = 1'b0;
        per_frame_vsync = 1'b0;
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        per_img_Bit     = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("rst_x_min",  int'(box_x_min), 0);
        chk("rst_x_max",  int'(box_x_max), 0);
        chk("rst_y_min",  int'(box_y_min), 0);
        chk("rst_y_max",  int'(box_y_max), 0);
        chk("rst_cnt",    int'(box_pix_cnt), 0);
        chk("rst_valid",  int'(box_valid), 0);
        chk("rst_update", int'(box_update), 0);
        sys_rst_n = 1'b1;
        repeat (2) @(negedge sys_clk);

        for (int i = 0; i < 7; i++) begin
            drive_frame(i, -1);
            wait_update(vecs[i].name);
        end

        // Outputs hold the last published box while idle.
        repeat (20) @(negedge sys_clk);
        chk("hold_y_min", int'(box_y_min), 479);
        chk("hold_x_max", int'(box_x_max), 15);
        chk("hold_valid", int'(box_valid), 1);

        // Reset mid-frame: no update for that frame, outputs cleared.
        upd_before = n_upd;
        drive_frame(2, 200);
        repeat (10) @(negedge sys_clk);
        chk("abort_no_update", n_upd, upd_before);
        chk("abort_cnt_clear", int'(box_pix_cnt), 0);
        chk("abort_valid_clear", int'(box_valid), 0);

        // The following full frame (with clken gaps) reports correctly.
        drive_frame(4, -1);
        wait_update("after_abort");

        // Random mask stream with vsync low; monitor checks pass-through.
        for (int k = 0; k < 400; k++) begin
            per_frame_href  = 1'($urandom_range(0, 1));
            per_frame_clken = 1'($urandom_range(0, 1));
            per_img_Bit     = 1'($urandom_range(0, 1));
            @(negedge sys_clk);
        end
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        per_img_Bit     = 1'b0;
        repeat (3) @(negedge sys_clk);
        chk("random_no_update", n_upd, upd_before + 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
